ime_sad_search: RTL and testbench

- Integer motion estimation stage that sits directly upstream of the fractional ME block.
- Loads one 4x4 current block, then streams the reference pixels of NCAND integer candidate positions.
- Accumulates the sum of absolute differences (SAD) per candidate and keeps the minimum.
- Delivers the winning 8-bit candidate index on best_pos; this feeds the fractional ME pix_pos input.

---
 rtl/ime_sad_search_if.sv | 38 +++
 rtl/ime_sad_search.sv | 170 +++++++++++++++++
 tb/tb_ime_sad_search.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ime_sad_search_if.sv
// ---------------------------------------------------------------------------
// ime_sad_search_if
//
// Purpose:
//   Pixel stream handshake between a pixel source and the integer motion
//   estimation SAD search block. A transfer happens on a rising clock edge
//   when pix_valid and pix_ready are both high.
//
// Signals:
//   pix_in     pixel value, PIX_W bits, driven by the source
//   pix_valid  pix_in carries a valid pixel, driven by the source
//   pix_ready  the sink accepts pix_in this cycle, driven by the sink
//
// Modports:
//   master  pixel source (drives pix_in / pix_valid, observes pix_ready)
//   slave   pixel sink   (observes pix_in / pix_valid, drives pix_ready)
// ---------------------------------------------------------------------------
interface ime_sad_search_if #(
  parameter int PIX_W = 8
);

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_in,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/ime_sad_search.sv
// ---------------------------------------------------------------------------
// ime_sad_search
//
// Purpose:
//   Integer motion estimation stage. Loads one 4x4 current block, then
//   streams the reference pixels of NCAND integer candidate positions,
//   accumulates the sum of absolute differences (SAD) per candidate and
//   keeps the minimum. The winning candidate index (best_pos) feeds the
//   pix_pos input of the downstream fractional ME block.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     one-cycle request to begin a search, honoured only in IDLE
//   pix       pixel stream (slave side): BLK_PIX current pixels first, then
//             NCAND*BLK_PIX reference pixels, candidate-major, raster order
//   best_pos  index of the minimum-SAD candidate (lowest index on ties)
//   best_sad  SAD of best_pos
//   busy      high from start acceptance through the last candidate compare
//   done      one-cycle pulse while the result is valid (FINISH state)
// ---------------------------------------------------------------------------
module ime_sad_search #(
  parameter int PIX_W   = 8,
  parameter int BLK_PIX = 16,
  parameter int NCAND   = 256,
  parameter int SAD_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  ime_sad_search_if.slave          pix,
  output logic [$clog2(NCAND)-1:0] best_pos,
  output logic [SAD_W-1:0]         best_sad,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W  = $clog2(BLK_PIX);
  localparam int CAND_W = $clog2(NCAND);

  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(BLK_PIX - 1);
  localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(NCAND - 1);
  localparam logic [CNT_W-1:0]  PIX_ONE   = CNT_W'(1);
  localparam logic [CAND_W-1:0] CAND_ONE  = CAND_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_CUR,
    SEARCH,
    FINISH
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    pix_cnt;
  logic [CAND_W-1:0]   cand_cnt;
  logic [SAD_W-1:0]    sad_acc;
  logic [PIX_W-1:0]    cur [BLK_PIX];
  logic                ready;

  logic [PIX_W-1:0]    cur_pix;
  logic [PIX_W-1:0]    diff;
  logic [SAD_W-1:0]    sad_next;

  // pix_ready is a registered output; it is only ever high in LOAD_CUR and
  // SEARCH, so "ready && pix_valid" is the transfer condition in those states.
  assign pix.pix_ready = ready;

  // Absolute difference against the current-block pixel at the same raster
  // position, and the running SAD including this pixel. The subtraction is
  // ordered so the PIX_W-wide result never wraps. SAD_W is wide enough for
  // BLK_PIX maximal differences, so the sum needs no saturation.
  always_comb begin
    cur_pix  = cur[pix_cnt];
    diff     = (pix.pix_in >= cur_pix) ? (pix.pix_in - cur_pix)
                                       : (cur_pix - pix.pix_in);
    sad_next = sad_acc + SAD_W'(diff);
  end

  // Search controller. All outputs are registered here so that busy, done
  // and pix_ready change together with the state they belong to: entering
  // FINISH raises done and drops busy/pix_ready on the same edge that takes
  // the final reference pixel, so done is high in the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ready    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      best_pos <= '0;
      best_sad <= '1;
      pix_cnt  <= '0;
      cand_cnt <= '0;
      sad_acc  <= '0;
      for (int i = 0; i < BLK_PIX; i++) begin
        cur[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      case (state)
        // Waiting for a request. The previous result stays on best_pos /
        // best_sad until a new search is actually accepted.
        IDLE: begin
          if (start) begin
            state    <= LOAD_CUR;
            busy     <= 1'b1;
            ready    <= 1'b1;
            pix_cnt  <= '0;
            cand_cnt <= '0;
            sad_acc  <= '0;
            best_sad <= '1;
            best_pos <= '0;
          end
        end

        // Capture the current block in raster order.
        LOAD_CUR: begin
          if (pix.pix_valid) begin
            cur[pix_cnt] <= pix.pix_in;
            if (pix_cnt == PIX_LAST) begin
              pix_cnt <= '0;
              state   <= SEARCH;
            end else begin
              pix_cnt <= pix_cnt + PIX_ONE;
            end
          end
        end

        // Accumulate one candidate at a time. The compare is strict, so an
        // equal SAD from a later candidate never displaces an earlier one.
        // cand_cnt simply wraps after the last candidate; the wrapped value
        // is never used because the state leaves SEARCH on that edge.
        SEARCH: begin
          if (pix.pix_valid) begin
            if (pix_cnt == PIX_LAST) begin
              if (sad_next < best_sad) begin
                best_sad <= sad_next;
                best_pos <= cand_cnt;
              end
              sad_acc  <= '0;
              pix_cnt  <= '0;
              cand_cnt <= cand_cnt + CAND_ONE;
              if (cand_cnt == CAND_LAST) begin
                state <= FINISH;
                busy  <= 1'b0;
                ready <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              sad_acc <= sad_next;
              pix_cnt <= pix_cnt + PIX_ONE;
            end
          end
        end

        // Single result cycle; start is deliberately not looked at here.
        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ime_sad_search.sv
// ---------------------------------------------------------------------------
// tb_ime_sad_search
//
// Purpose:
//   Self-checking bench for ime_sad_search. Directed pixel patterns are
//   streamed through the interface; a behavioural model computes the winning
//   candidate from plain per-candidate SAD sums, and a compare process checks
//   the handshake and result outputs on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_ime_sad_search;

  localparam int BLK    = 16;
  localparam int NC     = 256;
  localparam int TOTAL  = BLK + NC * BLK;
  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  best_pos;
  logic [11:0] best_sad;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  int exp_pos;
  int exp_sad;

  bit active;
  bit fin;
  int xfers;
  int hold_pos;
  int hold_sad;

  always #5 clk = ~clk;

  ime_sad_search_if #(.PIX_W(8)) pix_bus ();

  ime_sad_search dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pix      (pix_bus),
    .best_pos (best_pos),
    .best_sad (best_sad),
    .busy     (busy),
    .done     (done)
  );

  // Pixel patterns for each directed test
  function automatic int cur_val(input int test, input int i);
    case (test)
      1:       return 'h10;
      2:       return 'h80;
      3:       return 'hFF;
      4:       return 'h33;
      default: return (i * 16 + 3) & 255;
    endcase
  endfunction

  function automatic int ref_val(input int test, input int k, input int i);
    case (test)
      1:       return (k == 37) ? 'h10 : 'h11;
      2:       return (k == 5 || k == 200) ? 'h7F : 'h00;
      3:       return 'h00;
      4:       return 'h33;
      default: return (i * 16 + 3 + k * 7 + i * k) & 255;
    endcase
  endfunction

  function automatic int stream_val(input int test, input int idx);
    if (idx < BLK) return cur_val(test, idx);
    return ref_val(test, (idx - BLK) / BLK, (idx - BLK) % BLK);
  endfunction

  // Behavioural model: full SAD per candidate, first strict minimum wins
  task automatic modelSearch(input int test, output int pos, output int sad);
    int best;
    pos  = 0;
    best = 0;
    for (int k = 0; k < NC; k++) begin
      int s;
      s = 0;
      for (int i = 0; i < BLK; i++) begin
        int a;
        int b;
        a = ref_val(test, k, i);
        b = cur_val(test, i);
        s += (a > b) ? (a - b) : (b - a);
      end
      if (k == 0 || s < best) begin
        best = s;
        pos  = k;
      end
    end
    sad = best;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction tracker: follows accepted starts and counted transfers from
  // the bench's own view of the handshake to know when the result is due.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   = 1'b0;
      fin      = 1'b0;
      xfers    = 0;
      hold_pos = 0;
      hold_sad = 'hFFF;
    end else begin
      bit was_fin;
      was_fin = fin;
      fin     = 1'b0;
      if (active) begin
        if (pix_bus.pix_valid) begin
          xfers++;
          if (xfers == TOTAL) begin
            active   = 1'b0;
            fin      = 1'b1;
            hold_pos = exp_pos;
            hold_sad = exp_sad;
          end
        end
      end else if (!was_fin && start) begin
        active = 1'b1;
        xfers  = 0;
      end
    end
  end

  // Compare process: every falling edge
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rst_busy",      int'(busy), 0);
      checkOutput("rst_pix_ready", int'(pix_bus.pix_ready), 0);
      checkOutput("rst_done",      int'(done), 0);
      checkOutput("rst_best_pos",  int'(best_pos), 0);
      checkOutput("rst_best_sad",  int'(best_sad), 'hFFF);
    end else begin
      checkOutput("pix_ready", int'(pix_bus.pix_ready), int'(active));
      checkOutput("busy",      int'(busy), int'(active));
      checkOutput("done",      int'(done), int'(fin));
      if (!active) begin
        checkOutput("best_pos", int'(best_pos), hold_pos);
        checkOutput("best_sad", int'(best_sad), hold_sad);
      end
    end
  end

  // Run one search: start pulse, then stream all pixels with optional
  // random stalls, an optional ignored start pulse and an optional abort.
  task automatic applyStimulus(input int test, input int stall_pct,
                               input int glitch_idx, input int abort_idx);
    int idx;
    int cycles;
    bit glitched;
    modelSearch(test, exp_pos, exp_sad);
    idx      = 0;
    cycles   = 0;
    glitched = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < TOTAL) begin
      @(negedge clk);
      cycles++;
      if (cycles > BUDGET) begin
        checks++;
        failures++;
        $display("[TB] FAIL timeout test=%0d transfers=%0d required=%0d", test, idx, TOTAL);
        pix_bus.pix_valid = 1'b0;
        return;
      end
      if (abort_idx >= 0 && idx == abort_idx) begin
        pix_bus.pix_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_busy",      int'(busy), 0);
        checkOutput("abort_pix_ready", int'(pix_bus.pix_ready), 0);
        checkOutput("abort_done",      int'(done), 0);
        checkOutput("abort_best_sad",  int'(best_sad), 'hFFF);
        checkOutput("abort_best_pos",  int'(best_pos), 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        return;
      end
      if (!glitched && idx == glitch_idx) begin
        start    = 1'b1;
        glitched = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (pix_bus.pix_ready && ($urandom_range(0, 99) >= stall_pct)) begin
        pix_bus.pix_valid = 1'b1;
        pix_bus.pix_in    = 8'(stream_val(test, idx));
        idx++;
      end else begin
        pix_bus.pix_valid = 1'b0;
      end
    end
    @(negedge clk);
    pix_bus.pix_valid = 1'b0;
    start             = 1'b0;
  endtask

  // Idle cycles with junk on the bus; nothing may be accepted
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_bus.pix_valid = 1'(i & 1);
      pix_bus.pix_in    = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    pix_bus.pix_valid = 1'b0;
  endtask

  initial begin
    int p;
    int s;
    rst               = 1'b0;
    start             = 1'b0;
    pix_bus.pix_valid = 1'b0;
    pix_bus.pix_in    = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    modelSearch(1, p, s);
    checkOutput("model_basic_pos", p, 37);
    checkOutput("model_basic_sad", s, 0);
    modelSearch(2, p, s);
    checkOutput("model_tie_pos", p, 5);
    checkOutput("model_tie_sad", s, 16);
    modelSearch(3, p, s);
    checkOutput("model_max_pos", p, 0);
    checkOutput("model_max_sad", s, 4080);
    modelSearch(4, p, s);
    checkOutput("model_zero_pos", p, 0);
    checkOutput("model_zero_sad", s, 0);

    $display("[TB] basic search");
    applyStimulus(1, 0, -1, -1);
    idleCycles(5);

    $display("[TB] backpressure search");
    applyStimulus(1, 50, -1, -1);
    idleCycles(5);

    $display("[TB] tie / abs-diff search with ignored start");
    applyStimulus(2, 0, 500, -1);
    idleCycles(50);

    $display("[TB] max SAD search");
    applyStimulus(3, 0, -1, -1);
    idleCycles(5);

    $display("[TB] all-zero SAD search");
    applyStimulus(4, 0, -1, -1);
    idleCycles(5);

    $display("[TB] reset mid-search");
    applyStimulus(1, 0, -1, BLK + 100 * BLK + 5);
    idleCycles(5);

    $display("[TB] fresh search after reset, varied pixels");
    applyStimulus(5, 30, -1, -1);
    idleCycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
